// File: rtl/fc_pkg.sv
// Shared types and helpers for the sequential fully-connected layer.
package fc_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_BIAS = 2'd2,
      S_OUT  = 2'd3
   } fc_state_e;

   // Parameter memory holds N_OUT rows of N_IN weights followed by one bias.
   function automatic int fc_addr_w(input int n_out, input int n_in);
      int n;
      n = n_out * (n_in + 1);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   function automatic int fc_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed multiply-accumulate with synchronous clear; clear wins over enable.
module fc_mac_unit #(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 72
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] a_ext;
   logic signed [2*DATA_W-1:0] b_ext;
   logic signed [2*DATA_W-1:0] prod;
   logic [ACC_W-1:0]           acc_q;
   logic [ACC_W-1:0]           acc_d;

   always_comb begin
      a_ext = {{DATA_W{a[DATA_W-1]}}, a};
      b_ext = {{DATA_W{b[DATA_W-1]}}, b};
      prod  = a_ext * b_ext;
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/fc_seq_layer.sv
// Sequential fully-connected layer: one MAC per cycle, bias + saturation per neuron.
// Optional FC_RELU_EN clamps negative saturated results to zero.
module fc_seq_layer
   import fc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int N_IN   = 9,
   parameter int N_OUT  = 4,
   parameter int ACC_W  = 72,
   localparam int AW    = fc_addr_w(N_OUT, N_IN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N_IN*DATA_W-1:0]  in_data,
   input  logic                    wr_en,
   input  logic [AW-1:0]           wr_addr,
   input  logic [DATA_W-1:0]       wr_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_OUT*DATA_W-1:0] out_data,
   output logic                    busy
);

   localparam int N_PARAM = N_OUT * (N_IN + 1);
   localparam int IW      = fc_cnt_w(N_IN);
   localparam int OW      = fc_cnt_w(N_OUT);
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   fc_state_e                  state_q, state_d;
   logic [IW-1:0]              i_q, i_d;
   logic [OW-1:0]              o_q, o_d;
   logic [DATA_W-1:0]          x_q [N_IN];
   logic [DATA_W-1:0]          x_d [N_IN];
   logic [DATA_W-1:0]          prm_q [N_PARAM];
   logic [DATA_W-1:0]          prm_d [N_PARAM];
   logic [DATA_W-1:0]          result_q [N_OUT];
   logic [DATA_W-1:0]          result_d [N_OUT];
   logic [N_OUT*DATA_W-1:0]    out_data_q, out_data_d;
   logic                       out_valid_q, out_valid_d;
   logic                       in_ready_q, in_ready_d;
   logic                       busy_q, busy_d;

   logic                       mac_clr;
   logic                       mac_en;
   logic [AW-1:0]              widx;
   logic [AW-1:0]              bidx;
   logic [ACC_W-1:0]           acc;
   logic signed [ACC_W:0]      biased;
   logic [DATA_W-1:0]          sat;

   fc_mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (x_q[i_q]),
      .b   (prm_q[widx]),
      .acc (acc)
   );

   // Bias add is one bit wider than the accumulator so it can never wrap.
   always_comb begin
      widx   = AW'(int'(o_q) * (N_IN + 1) + int'(i_q));
      bidx   = AW'(int'(o_q) * (N_IN + 1) + N_IN);
      biased = $signed({acc[ACC_W-1], acc}) +
               $signed({{(ACC_W+1-DATA_W){prm_q[bidx][DATA_W-1]}}, prm_q[bidx]});
      if (biased > SAT_MAX) begin
         sat = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (biased < SAT_MIN) begin
         sat = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
         sat = biased[DATA_W-1:0];
      end
`ifdef FC_RELU_EN
      if (sat[DATA_W-1]) begin
         sat = '0;
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      o_d         = o_q;
      x_d         = x_q;
      prm_d       = prm_q;
      result_d    = result_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      mac_clr     = 1'b0;
      mac_en      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_en && (int'(wr_addr) < N_PARAM)) begin
               prm_d[wr_addr] = wr_data;
            end
            if (in_valid) begin
               for (int k = 0; k < N_IN; k++) begin
                  x_d[k] = in_data[k*DATA_W +: DATA_W];
               end
               i_d     = '0;
               o_d     = '0;
               mac_clr = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (i_q == IW'(N_IN - 1)) begin
               state_d = S_BIAS;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         S_BIAS: begin
            result_d[o_q] = sat;
            mac_clr       = 1'b1;
            i_d           = '0;
            if (o_q == OW'(N_OUT - 1)) begin
               state_d = S_OUT;
            end else begin
               o_d     = o_q + 1'b1;
               state_d = S_MAC;
            end
         end
         S_OUT: begin
            // First OUT cycle publishes the results; they then hold until taken.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               for (int k = 0; k < N_OUT; k++) begin
                  out_data_d[k*DATA_W +: DATA_W] = result_q[k];
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d = (state_d == S_IDLE);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         o_q         <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         for (int k = 0; k < N_IN; k++) x_q[k] <= '0;
         for (int k = 0; k < N_PARAM; k++) prm_q[k] <= '0;
         for (int k = 0; k < N_OUT; k++) result_q[k] <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         o_q         <= o_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         x_q         <= x_d;
         prm_q       <= prm_d;
         result_q    <= result_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fc_seq_layer.sv
// Directed bench for fc_seq_layer with an arithmetic reference model and per-cycle output compare.
module tb_fc_seq_layer;

   localparam int DW      = 32;
   localparam int NI      = 9;
   localparam int NO      = 4;
   localparam int NP      = NO * (NI + 1);
   localparam int LAT     = NO * (NI + 1) + 1;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [NI*DW-1:0] in_data;
   logic             wr_en;
   logic [5:0]       wr_addr;
   logic [DW-1:0]    wr_data;
   logic             out_valid;
   logic             out_ready;
   logic [NO*DW-1:0] out_data;
   logic             busy;

   fc_seq_layer #(
      .DATA_W (DW),
      .N_IN   (NI),
      .N_OUT  (NO),
      .ACC_W  (72)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- model and scoreboard ----------------
   logic signed [DW-1:0] w_m [NP];
   logic signed [DW-1:0] xv [NI];
   logic [NO*DW-1:0]     exp_q[$];
   logic [NO*DW-1:0]     last_out;
   logic [NO*DW-1:0]     held;
   int                   accept_cyc;
   int                   checks = 0;
   int                   errors = 0;
   bit                   prev_valid = 0;

   function automatic void check(input string name, input logic [NO*DW-1:0] act,
                                 input logic [NO*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Dot product + bias, saturated to 32-bit signed, optional negative clamp.
   function automatic logic [NO*DW-1:0] model();
      logic [NO*DW-1:0]   r;
      logic signed [79:0] s;
      logic signed [79:0] a80;
      logic signed [79:0] b80;
      logic [DW-1:0]      v;
      r = '0;
      for (int o = 0; o < NO; o++) begin
         s = 0;
         for (int i = 0; i < NI; i++) begin
            a80 = xv[i];
            b80 = w_m[o*(NI+1)+i];
            s   = s + a80 * b80;
         end
         b80 = w_m[o*(NI+1)+NI];
         s   = s + b80;
         if (s > 80'sd2147483647) v = 32'h7FFFFFFF;
         else if (s < -80'sd2147483648) v = 32'h80000000;
         else v = s[DW-1:0];
`ifdef FC_RELU_EN
         if (v[DW-1]) v = '0;
`endif
         r[o*DW +: DW] = v;
      end
      return r;
   endfunction

   // Compare process: results, first-valid latency, and handshake consistency.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 0;
      end else begin
         check("ready_vs_busy", {127'd0, in_ready}, {127'd0, ~busy});
         if (out_valid) begin
            if (!prev_valid) begin
               check("latency", (NO*DW)'(cyc - accept_cyc), (NO*DW)'(LAT));
            end
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stray_out_valid: got out_valid=1 expected no result pending");
            end else begin
               check("out_data", out_data, exp_q[0]);
               last_out = out_data;
               if (out_ready) void'(exp_q.pop_front());
            end
         end
         prev_valid = out_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_param(input int addr, input logic [DW-1:0] d, input bit upd);
      wr_en   = 1'b1;
      wr_addr = addr[5:0];
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (upd && addr < NP) w_m[addr] = d;
   endtask

   task automatic set_all(input logic [DW-1:0] wv, input logic [DW-1:0] bv);
      for (int a = 0; a < NP; a++) begin
         write_param(a, ((a % (NI+1)) == NI) ? bv : wv, 1'b1);
      end
   endtask

   task automatic set_mixed();
      for (int a = 0; a < NP; a++) begin
         int o;
         int i;
         o = a / (NI+1);
         i = a % (NI+1);
         if (i < NI) write_param(a, DW'((o+1)*(i-4)), 1'b1);
         else write_param(a, DW'(100*o - 150), 1'b1);
      end
   endtask

   task automatic send();
      int k;
      for (k = 0; k < 200; k++) begin
         if (in_ready) break;
         tick();
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
      end
      for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = xv[i];
      in_valid = 1'b1;
      tick();
      exp_q.push_back(model());
      accept_cyc = cyc;
      in_valid   = 1'b0;
      wr_en      = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 300; k++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      check("result_timeout", {96'd0, 32'(exp_q.size())}, '0);
      exp_q.delete();
   endtask

   task automatic check_word(input string name, input int o, input logic [DW-1:0] exp);
      logic [NO*DW-1:0] lo;
      lo = last_out;
      check(name, {96'd0, lo[o*DW +: DW]}, {96'd0, exp});
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      out_ready = 1'b1;
      last_out  = '0;
      for (int a = 0; a < NP; a++) w_m[a] = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("reset_in_ready", {127'd0, in_ready}, 128'd1);
      check("reset_busy", {127'd0, busy}, '0);
      check("reset_out_valid", {127'd0, out_valid}, '0);
      check("reset_out_data", out_data, '0);

      // weights 1, inputs 1..9 -> 45
      set_all(32'd1, 32'd0);
      for (int i = 0; i < NI; i++) xv[i] = DW'(i + 1);
      send();
      wait_done();
      for (int o = 0; o < NO; o++) check_word("sum45", o, 32'd45);

      // positive and negative saturation
      set_all(32'd2, 32'd0);
      for (int i = 0; i < NI; i++) xv[i] = 32'h7FFFFFFF;
      send();
      wait_done();
      check_word("sat_pos0", 0, 32'h7FFFFFFF);
      check_word("sat_pos3", 3, 32'h7FFFFFFF);
      set_all(-32'sd2, 32'd0);
      send();
      wait_done();
      check_word("sat_neg0", 0, 32'h80000000);
      check_word("sat_neg3", 3, 32'h80000000);

      // negative result: clamped with FC_RELU_EN, -9 otherwise
      set_all(-32'sd1, 32'd0);
      for (int i = 0; i < NI; i++) xv[i] = 32'd1;
      send();
      wait_done();
`ifdef FC_RELU_EN
      check_word("neg_relu", 2, 32'd0);
`else
      check_word("neg_plain", 2, -32'sd9);
`endif

      // mixed weights/biases with output back-pressure
      set_mixed();
      for (int i = 0; i < NI; i++) xv[i] = DW'(3*i - 7);
      out_ready = 1'b0;
      send();
      for (int k = 0; k < LAT + 5; k++) begin
         if (out_valid) break;
         tick();
      end
      check("stall_valid_seen", {127'd0, out_valid}, 128'd1);
      held = out_data;
      repeat (5) begin
         tick();
         check("stall_in_ready", {127'd0, in_ready}, '0);
         check("stall_valid", {127'd0, out_valid}, 128'd1);
         check("stall_hold", out_data, held);
      end
      out_ready = 1'b1;
      tick();
      check("release_in_ready", {127'd0, in_ready}, 128'd1);
      check("release_valid", {127'd0, out_valid}, '0);
      wait_done();
      check_word("mixed0", 0, 32'd30);
      check_word("mixed1", 1, 32'd310);
      check_word("mixed2", 2, 32'd590);
      check_word("mixed3", 3, 32'd870);

      // write while busy is ignored
      send();
      repeat (3) tick();
      write_param(0, 32'd999, 1'b0);
      wait_done();
      check_word("busy_write", 0, 32'd30);

      // write and accept on the same edge: new w[0][0]=5 is used
      wr_en   = 1'b1;
      wr_addr = 6'd0;
      wr_data = 32'd5;
      w_m[0]  = 32'd5;
      send();
      wait_done();
`ifdef FC_RELU_EN
      check_word("same_edge", 0, 32'd0);
`else
      check_word("same_edge", 0, -32'sd33);
`endif

      // out-of-range addresses are ignored
      write_param(45, 32'h12345678, 1'b1);
      write_param(63, 32'h0BADF00D, 1'b1);
      send();
      wait_done();
      check_word("oob_write", 1, 32'd310);

      // reset 20 cycles into a computation
      send();
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      for (int a = 0; a < NP; a++) w_m[a] = '0;
      check("abort_out_valid", {127'd0, out_valid}, '0);
      check("abort_in_ready", {127'd0, in_ready}, 128'd1);
      check("abort_busy", {127'd0, busy}, '0);
      repeat (60) tick();
      send();
      wait_done();
      for (int o = 0; o < NO; o++) check_word("zero_weights", o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
